fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the CPU core. It holds the fetch PC and drives a synchronous-read instruction ROM. Returned words are buffered in a small queue and presented to decode over a valid/ready handshake. Unlike the original single-cycle fetch path, it supports decode back-pressure, queue buffering and four next-PC modes, and a redirect kills in-flight and queued fetches.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 41 ++++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared CPU types and defaults (next-PC modes, XLEN, reset PC).
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ  = 2'b00,
        NPC_BR   = 2'b01,
        NPC_JAL  = 2'b10,
        NPC_JALR = 2'b11
    } npc_op_e;

    localparam int          CPU_XLEN     = 32;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Redirect, IROM and decode-handshake signals of the fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int XLEN    = CPU_XLEN,
    parameter int IADDR_W = 14
) ();

    logic [1:0]         redir_op;
    logic               br;
    logic [XLEN-1:0]    redir_base;
    logic [XLEN-1:0]    offset;
    logic               imem_en;
    logic [IADDR_W-1:0] imem_addr;
    logic [XLEN-1:0]    imem_data;
    logic               inst_valid;
    logic               inst_ready;
    logic [XLEN-1:0]    inst;
    logic [XLEN-1:0]    inst_pc;
    logic [XLEN-1:0]    inst_pc4;
    logic               redir_taken;

    modport master (
        input  redir_op, br, redir_base, offset, imem_data, inst_ready,
        output imem_en, imem_addr, inst_valid, inst, inst_pc, inst_pc4, redir_taken
    );

    modport slave (
        output redir_op, br, redir_base, offset, imem_data, inst_ready,
        input  imem_en, imem_addr, inst_valid, inst, inst_pc, inst_pc4, redir_taken
    );

endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Brief    : Small power-of-two FIFO with synchronous flush and count output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_flush,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic             i_pop,
    output      logic [WIDTH-1:0] o_rdata,
    output      logic             o_valid,
    output      logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Flush wins over any same-cycle push or pop.
    assign w_do_push = i_push && !i_flush;
    assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage: PC, next-PC select, IROM credit, queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN     = CPU_XLEN,
    parameter int              IADDR_W  = 14,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(CPU_RESET_PC)
) (
    input  wire logic    clk,
    input  wire logic    rst,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    npc_op_e         w_op;
    logic            w_redir;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_target;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [CW:0]     w_credit;
    logic [CW-1:0]   w_count;
    logic [2*XLEN-1:0] w_head;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_inflight;
    logic            r_kill;

    assign w_op = npc_op_e'(bus.redir_op);

    always_comb begin
        w_redir = 1'b0;
        case (w_op)
            NPC_BR:            w_redir = bus.br;
            NPC_JAL, NPC_JALR: w_redir = 1'b1;
            default:           w_redir = 1'b0;
        endcase
    end

    assign w_sum    = bus.redir_base + bus.offset;
    assign w_target = w_sum & ~XLEN'(3);

    // Credit counts the outstanding request so the queue can never overflow.
    assign w_pop    = bus.inst_valid && bus.inst_ready;
    assign w_credit = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    assign w_issue  = !rst && !w_redir && (w_credit < (CW+1)'(DEPTH));
    assign w_push   = r_inflight && !r_kill && !w_redir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            if (w_redir) begin
                r_pc <= w_target;
            end else if (w_issue) begin
                r_pc <= r_pc + XLEN'(4);
            end
            if (w_issue) begin
                r_req_pc <= r_pc;
            end
            r_inflight <= w_issue;
            r_kill     <= w_redir;
        end
    end

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_redir),
        .i_push  (w_push),
        .i_wdata ({r_req_pc, bus.imem_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_valid (bus.inst_valid),
        .o_count (w_count)
    );

    assign bus.imem_en     = w_issue;
    assign bus.imem_addr   = r_pc[IADDR_W+1:2];
    assign bus.redir_taken = w_redir;
    assign bus.inst        = w_head[XLEN-1:0];
    assign bus.inst_pc     = w_head[2*XLEN-1:XLEN];
    assign bus.inst_pc4    = w_head[2*XLEN-1:XLEN] + XLEN'(4);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit against a program-order model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int          XLEN     = 32;
    localparam int          IADDR_W  = 14;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(XLEN), .IADDR_W(IADDR_W)) bus ();

    fetch_unit #(
        .XLEN     (XLEN),
        .IADDR_W  (IADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;
    logic        obs_en;
    logic        obs_valid;
    logic [13:0] obs_addr;
    logic [31:0] obs_pc;

    function automatic logic [31:0] rom_word(input logic [IADDR_W-1:0] a);
        return ({18'h0, a} * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] rom_at(input logic [31:0] pc);
        return rom_word(pc[IADDR_W+1:2]);
    endfunction

    // Synchronous-read instruction ROM
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_data <= rom_word(bus.imem_addr);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle from a negedge: drive, check the head against program order, advance.
    task automatic step(input logic [1:0] op, input logic b, input logic [31:0] base,
                        input logic [31:0] off, input logic rdy);
        logic        exp_r;
        logic [31:0] tgt;
        bus.redir_op   = op;
        bus.br         = b;
        bus.redir_base = base;
        bus.offset     = off;
        bus.inst_ready = rdy;
        #1;
        exp_r     = (op == 2'b01) ? b : op[1];
        tgt       = (base + off) & ~32'h3;
        obs_en    = bus.imem_en;
        obs_valid = bus.inst_valid;
        obs_addr  = bus.imem_addr;
        obs_pc    = bus.inst_pc;
        check_eq("redir_taken", bus.redir_taken, exp_r);
        if (exp_r) begin
            check_eq("en_on_redir", bus.imem_en, 1'b0);
            exp_pc = tgt;
        end else if (bus.inst_valid) begin
            check_eq("inst_pc", bus.inst_pc, exp_pc);
            check_eq("inst", bus.inst, rom_at(exp_pc));
            check_eq("inst_pc4", bus.inst_pc4, exp_pc + 32'd4);
            if (rdy) exp_pc = exp_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(2'b00, 1'b0, 32'h0, 32'h0, rdy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        bus.redir_op   = 2'b00;
        bus.br         = 1'b0;
        bus.redir_base = '0;
        bus.offset     = '0;
        bus.inst_ready = 1'b0;
        exp_pc         = RESET_PC;

        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_valid", bus.inst_valid, 1'b0);
        check_eq("rst_inst", bus.inst, 32'h0);
        check_eq("rst_pc", bus.inst_pc, 32'h0);
        check_eq("rst_pc4", bus.inst_pc4, 32'h4);
        check_eq("rst_en", bus.imem_en, 1'b0);

        // Release: sequential fetch, first valid two cycles after first strobe
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idle(1'b1);
            check_eq("rel_addr", obs_addr, 64'(k));
            check_eq("rel_en", obs_en, 1'b1);
            check_eq("rel_valid", obs_valid, (k >= 2) ? 1'b1 : 1'b0);
        end

        // Back-pressure fills the queue, then drains without gap
        for (int k = 0; k < 10; k++) idle(1'b0);
        check_eq("full_en", obs_en, 1'b0);
        for (int k = 0; k < 8; k++) begin
            idle(1'b1);
            check_eq("drain_valid", obs_valid, 1'b1);
        end

        // Taken branch while the queue is partly full
        idle(1'b0);
        idle(1'b0);
        step(2'b01, 1'b1, 32'h40, 32'h20, 1'b0);
        first = -1;
        for (int k = 0; k < 6; k++) begin
            idle(1'b1);
            if (k == 0) begin
                check_eq("br_addr", obs_addr, 64'(32'h60 >> 2));
                check_eq("br_en", obs_en, 1'b1);
            end
            if (obs_valid && first < 0) begin
                first = k;
                check_eq("br_first_pc", obs_pc, 32'h60);
            end
        end
        check_eq("br_latency", 64'(first), 64'(2));

        // Not-taken branch: stream continues
        step(2'b01, 1'b0, 32'h40, 32'h20, 1'b1);
        for (int k = 0; k < 3; k++) idle(1'b1);

        // JALR clears low bits
        step(2'b11, 1'b0, 32'h103, 32'h0, 1'b1);
        first = -1;
        for (int k = 0; k < 6; k++) begin
            idle(1'b1);
            if (obs_valid && first < 0) begin
                first = k;
                check_eq("jalr_first_pc", obs_pc, 32'h100);
            end
        end
        check_eq("jalr_latency", 64'(first), 64'(2));

        // JAL coinciding with a pop and an arriving response
        idle(1'b1);
        check_eq("pre_jal_valid", obs_valid, 1'b1);
        step(2'b10, 1'b0, 32'h200, 32'h10, 1'b1);
        first = -1;
        for (int k = 0; k < 6; k++) begin
            idle(1'b1);
            if (obs_valid && first < 0) begin
                first = k;
                check_eq("jal_first_pc", obs_pc, 32'h210);
            end
        end

        // Asynchronous reset mid-stream
        rst = 1'b1;
        #1;
        check_eq("arst_valid", bus.inst_valid, 1'b0);
        check_eq("arst_en", bus.imem_en, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        exp_pc = RESET_PC;
        idle(1'b1);
        check_eq("arst_addr", obs_addr, 64'(RESET_PC >> 2));
        check_eq("arst_en1", obs_en, 1'b1);
        for (int k = 0; k < 4; k++) idle(1'b1);

        // Randomized traffic with wrapping targets
        for (int k = 0; k < 400; k++) begin
            logic [1:0]  op;
            logic [31:0] base;
            logic [31:0] off;
            op   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            base = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_FFFF) : $urandom;
            off  = ($urandom_range(0, 1) == 0) ? 32'($signed(8'($urandom))) : $urandom;
            step(op, 1'($urandom), base, off, ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
